// File: rtl/updown_key_conditioner_pkg.sv
// Shared definitions for the up/down key conditioner.
//   chan_state_e : per-button channel FSM states
//   *_DEF        : default timing constants
//   max_u        : helper used by the elaboration-time timer width check
package updown_key_conditioner_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_DEB_PRESS   = 3'd1,
    ST_PRESSED     = 3'd2,
    ST_REPEAT      = 3'd3,
    ST_DEB_RELEASE = 3'd4
  } chan_state_e;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned REPEAT_DELAY_DEF    = 16;
  localparam int unsigned REPEAT_PERIOD_DEF   = 4;
  localparam int unsigned CNT_W_DEF           = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/updown_key_conditioner_key_channel.sv
// key_channel: one pushbutton channel.
//   clock   : system clock, all flops on posedge
//   clear_b : synchronous active-high reset
//   raw     : asynchronous raw button level (1 = pressed)
//   pulse   : registered one-cycle press / auto-repeat strobe
//   held    : registered, 1 while the channel is in PRESSED or REPEAT
// Two-flop synchroniser feeding a debounce / auto-repeat FSM with a shared timer.
module key_channel
  import updown_key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic clear_b,
  input  logic raw,
  output logic pulse,
  output logic held
);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("key_channel: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("key_channel: REPEAT_PERIOD must be >= 2");
  end
  if (((64'd1 << CNT_W) - 64'd1) < 64'(max_u(DEBOUNCE_CYCLES, REPEAT_DELAY))) begin : g_bad_cnt_w
    $error("key_channel: CNT_W too narrow for max(DEBOUNCE_CYCLES, REPEAT_DELAY)");
  end

  // "t+1 == N" is evaluated as "t == N-1" so the timer never has to reach N.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             pulse_q, pulse_d;
  logic             held_q, held_d;

  always_comb begin
    s1_d    = raw;
    s2_d    = s1_q;
    state_d = state_q;
    t_d     = t_q;
    pulse_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          state_d = ST_DEB_PRESS;
          t_d     = T_ONE;
        end
      end
      ST_DEB_PRESS: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
          t_d     = '0;
        end else if (t_q == DEB_LAST) begin
          state_d = ST_PRESSED;
          pulse_d = 1'b1;
          t_d     = '0;
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      ST_PRESSED: begin
        if (!s2_q) begin
          state_d = ST_DEB_RELEASE;
          t_d     = T_ONE;
        end else if (t_q == DLY_LAST) begin
          state_d = ST_REPEAT;
          pulse_d = 1'b1;
          t_d     = '0;
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      ST_REPEAT: begin
        if (!s2_q) begin
          state_d = ST_DEB_RELEASE;
          t_d     = T_ONE;
        end else if (t_q == PER_LAST) begin
          pulse_d = 1'b1;
          t_d     = '0;
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      ST_DEB_RELEASE: begin
        // A bounce during release resumes the existing press without a new pulse.
        if (s2_q) begin
          state_d = ST_PRESSED;
          t_d     = '0;
        end else if (t_q == DEB_LAST) begin
          state_d = ST_IDLE;
          t_d     = '0;
        end else begin
          t_d = t_q + T_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        t_d     = '0;
      end
    endcase

    held_d = (state_d == ST_PRESSED) || (state_d == ST_REPEAT);
  end

  always_ff @(posedge clock) begin
    if (clear_b) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= ST_IDLE;
      t_q     <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      t_q     <= t_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign pulse = pulse_q;
  assign held  = held_q;

endmodule

// File: rtl/updown_key_conditioner.sv
// updown_key_conditioner: turns two raw pushbutton levels into clean, mutually
// exclusive one-cycle up/down count-enable pulses for the 4-bit up/down counter.
//   clock        : system clock
//   clear_b      : synchronous active-high reset
//   btn_up_raw   : raw "up" button level
//   btn_down_raw : raw "down" button level
//   up / down    : registered one-cycle count pulses (never both 1)
//   conflict     : registered one-cycle flag, coincident pulses were dropped
//   held_up      : up channel in PRESSED or REPEAT
//   held_down    : down channel in PRESSED or REPEAT
module updown_key_conditioner
  import updown_key_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic clock,
  input  logic clear_b,
  input  logic btn_up_raw,
  input  logic btn_down_raw,
  output logic up,
  output logic down,
  output logic conflict,
  output logic held_up,
  output logic held_down
);

  logic pu, pd;
  logic up_q, up_d;
  logic down_q, down_d;
  logic conflict_q, conflict_d;

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W)
  ) u_up (
    .clock   (clock),
    .clear_b (clear_b),
    .raw     (btn_up_raw),
    .pulse   (pu),
    .held    (held_up)
  );

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .CNT_W           (CNT_W)
  ) u_down (
    .clock   (clock),
    .clear_b (clear_b),
    .raw     (btn_down_raw),
    .pulse   (pd),
    .held    (held_down)
  );

  always_comb begin
    up_d       = pu & ~pd;
    down_d     = pd & ~pu;
    conflict_d = pu & pd;
  end

  always_ff @(posedge clock) begin
    if (clear_b) begin
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      up_q       <= up_d;
      down_q     <= down_d;
      conflict_q <= conflict_d;
    end
  end

  assign up       = up_q;
  assign down     = down_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_updown_key_conditioner.sv
// Bench for updown_key_conditioner with a downstream 4-bit up/down counter.
// Expected output pulses are queued with their edge number when stimulus is
// driven; a negedge monitor pops and compares them as the DUT produces pulses.
module tb_updown_key_conditioner;

  logic clk = 1'b0;
  logic clear_b = 1'b0;
  logic btn_up_raw = 1'b0;
  logic btn_down_raw = 1'b0;
  logic up, down, conflict, held_up, held_down;

  localparam logic [2:0] K_UP   = 3'b001;
  localparam logic [2:0] K_DOWN = 3'b010;
  localparam logic [2:0] K_CONF = 3'b100;

  typedef struct {
    int         edge_n;
    logic [2:0] kind;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  logic mon_en = 1'b0;
  logic [3:0] cnt = 4'd0;

  updown_key_conditioner dut (
    .clock        (clk),
    .clear_b      (clear_b),
    .btn_up_raw   (btn_up_raw),
    .btn_down_raw (btn_down_raw),
    .up           (up),
    .down         (down),
    .conflict     (conflict),
    .held_up      (held_up),
    .held_down    (held_down)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Downstream 4-bit up/down counter.
  always @(posedge clk) begin
    if (clear_b)   cnt <= 4'd0;
    else if (up)   cnt <= cnt + 4'd1;
    else if (down) cnt <= cnt - 4'd1;
  end

  // Scoreboard monitor.
  logic [2:0] obs;
  int         exp_edge;
  logic [2:0] exp_kind;
  always @(negedge clk) begin
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].edge_n < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missed_pulse: got no pulse of kind %b at edge %0d, required it (now edge %0d)",
                 exp_q[0].kind, exp_q[0].edge_n, cyc);
        void'(exp_q.pop_front());
      end
      obs = {conflict, down, up};
      if (obs !== 3'b000) begin
        vectors++;
        exp_edge = (exp_q.size() > 0) ? exp_q[0].edge_n : -1;
        exp_kind = (exp_q.size() > 0) ? exp_q[0].kind : 3'b000;
        if (exp_edge != cyc || exp_kind !== obs) begin
          miscompares++;
          $display("FAIL pulse: got kind %b at edge %0d, required kind %b at edge %0d",
                   obs, cyc, exp_kind, exp_edge);
        end
        if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) void'(exp_q.pop_front());
      end
    end
  end

  task automatic push_exp(input int e, input logic [2:0] k);
    exp_t x;
    x.edge_n = e;
    x.kind   = k;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_b      = 1'b1;
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    @(negedge clk);
    clear_b = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    btn_up_raw   = 1'b1;
    btn_down_raw = 1'b1;
    clear_b      = 1'b1;
    repeat (3) @(negedge clk);
    vectors += 5;
    if (up !== 1'b0)        begin miscompares++; $display("FAIL reset_up: got %b, required 0", up); end
    if (down !== 1'b0)      begin miscompares++; $display("FAIL reset_down: got %b, required 0", down); end
    if (conflict !== 1'b0)  begin miscompares++; $display("FAIL reset_conflict: got %b, required 0", conflict); end
    if (held_up !== 1'b0)   begin miscompares++; $display("FAIL reset_held_up: got %b, required 0", held_up); end
    if (held_down !== 1'b0) begin miscompares++; $display("FAIL reset_held_down: got %b, required 0", held_down); end
    btn_up_raw   = 1'b0;
    btn_down_raw = 1'b0;
    mon_en       = 1'b1;
  endtask

  task automatic test_clean_press();
    int b;
    logic exp_h;
    do_reset();
    b = cyc;
    push_exp(b + 7, K_UP);
    for (int k = 0; k <= 25; k++) begin
      if (k != 0) @(negedge clk);
      btn_up_raw = (k < 8);
      exp_h = (k >= 6 && k <= 10);
      vectors++;
      if (held_up !== exp_h) begin
        miscompares++;
        $display("FAIL clean_held_up k=%0d: got %b, required %b", k, held_up, exp_h);
      end
    end
    vectors += 2;
    if (cnt !== 4'd1) begin miscompares++; $display("FAIL clean_count: got %0d, required 1", cnt); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL clean_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_bounce();
    logic [15:0] pat;
    pat = 16'h00E7; // high 3, low 2, high 3
    do_reset();
    for (int k = 0; k <= 25; k++) begin
      if (k != 0) @(negedge clk);
      btn_down_raw = (k < 16) ? pat[k] : 1'b0;
      vectors++;
      if (held_down !== 1'b0) begin
        miscompares++;
        $display("FAIL bounce_held_down k=%0d: got %b, required 0", k, held_down);
      end
    end
    vectors++;
    if (cnt !== 4'd0) begin miscompares++; $display("FAIL bounce_count: got %0d, required 0", cnt); end
  endtask

  task automatic test_auto_repeat();
    int b;
    logic exp_h;
    int edges[7] = '{7, 23, 27, 31, 35, 39, 43};
    do_reset();
    b = cyc;
    foreach (edges[i]) push_exp(b + edges[i], K_UP);
    for (int k = 0; k <= 60; k++) begin
      if (k != 0) @(negedge clk);
      btn_up_raw = (k < 40);
      exp_h = (k >= 6 && k <= 42);
      vectors++;
      if (held_up !== exp_h) begin
        miscompares++;
        $display("FAIL repeat_held_up k=%0d: got %b, required %b", k, held_up, exp_h);
      end
    end
    vectors += 2;
    if (cnt !== 4'd7) begin miscompares++; $display("FAIL repeat_count: got %0d, required 7", cnt); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL repeat_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_coincident();
    int b;
    logic exp_h;
    do_reset();
    b = cyc;
    push_exp(b + 7, K_CONF);
    for (int k = 0; k <= 25; k++) begin
      if (k != 0) @(negedge clk);
      btn_up_raw   = (k < 10);
      btn_down_raw = (k < 10);
      exp_h = (k >= 6 && k <= 12);
      vectors++;
      if (held_up !== exp_h || held_down !== exp_h) begin
        miscompares++;
        $display("FAIL coincident_held k=%0d: got %b%b, required %b%b", k, held_up, held_down, exp_h, exp_h);
      end
    end
    vectors++;
    if (cnt !== 4'd0) begin miscompares++; $display("FAIL coincident_count: got %0d, required 0", cnt); end
  endtask

  task automatic test_reset_mid_repeat();
    int b;
    do_reset();
    b = cyc;
    push_exp(b + 7, K_UP);
    push_exp(b + 23, K_UP);
    push_exp(b + 32, K_UP); // reset at edge b+25, re-press counts from b+26
    for (int k = 0; k <= 50; k++) begin
      if (k != 0) @(negedge clk);
      btn_up_raw = (k < 34);
      clear_b    = (k == 24);
      if (k == 24) begin
        vectors++;
        if (held_up !== 1'b1) begin miscompares++; $display("FAIL midrst_held_before: got %b, required 1", held_up); end
      end
      if (k == 25) begin
        vectors += 2;
        if (held_up !== 1'b0) begin miscompares++; $display("FAIL midrst_held_after: got %b, required 0", held_up); end
        if (up !== 1'b0)      begin miscompares++; $display("FAIL midrst_up_after: got %b, required 0", up); end
      end
      if (k == 31) begin
        vectors++;
        if (held_up !== 1'b1) begin miscompares++; $display("FAIL midrst_held_repress: got %b, required 1", held_up); end
      end
    end
    vectors += 2;
    if (cnt !== 4'd1) begin miscompares++; $display("FAIL midrst_count: got %0d, required 1", cnt); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL midrst_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int b;
    do_reset();
    b = cyc;
    for (int p = 0; p < 4; p++) push_exp(b + 12 * p + 7, (p < 3) ? K_UP : K_DOWN);
    for (int k = 0; k <= 60; k++) begin
      if (k != 0) @(negedge clk);
      btn_up_raw   = (k < 36) && ((k % 12) < 6);
      btn_down_raw = (k >= 36) && (k < 48) && ((k % 12) < 6);
      vectors++;
      if ((up & down) !== 1'b0) begin
        miscompares++;
        $display("FAIL seq_exclusive k=%0d: got up=%b down=%b, required not both", k, up, down);
      end
    end
    vectors += 2;
    if (cnt !== 4'd2) begin miscompares++; $display("FAIL seq_count: got %0d, required 2", cnt); end
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL seq_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_coincident();
    test_reset_mid_repeat();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, required completion before 100000 time units");
    $fatal(1);
  end

endmodule
